// File: rtl/compare_seq_pkg.sv
// Shared definitions for the bit-serial compare sequencer.
// - State encoding for the sequencer FSM. Encoding 2'd3 is illegal and
//   recovers to IDLE.
// - idx_w(): derives the mismatch-index width from the operand width.
package compare_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  // Enough bits to address every operand bit position.
  function automatic int idx_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/xnor_B_to_A.sv
// Single two-input XNOR cell shared by the compare sequencer.
// Ports:
//   DigitSupply [1:0] : supply-rail pair; carried through for the gate-level
//                       netlist, no effect on the logical function
//   A, B              : data inputs
//   Y                 : ~(A ^ B), purely combinational
module xnor_B_to_A (
  input  logic [1:0] DigitSupply,
  input  logic       A,
  input  logic       B,
  output logic       Y
);

  // Rails have no logical role in the behavioural model.
  logic supply_unused;
  assign supply_unused = ^DigitSupply;

  assign Y = ~(A ^ B);

endmodule

// File: rtl/serial_compare_sequencer.sv
// Bit-serial equality compare. Streams two WIDTH-bit operands LSB first
// through one shared XNOR cell, one bit per clock, and reports whether all
// compared bits matched plus the lowest mismatching bit position.
// Ports:
//   Clock, Reset       : single clock, synchronous active-high reset
//   DigitSupply [1:0]  : supply pair forwarded to the XNOR cell
//   Start              : request a compare (taken only when idle)
//   EarlyExit          : latched with Start; stop at the first mismatch
//   OperandA/OperandB  : operands, latched on the accept edge
//   Busy               : accept edge until the DONE state is left
//   Done               : one-cycle result-valid pulse
//   Equal              : all compared bits matched
//   MismatchIndex      : lowest mismatching bit (0 when Equal)
module serial_compare_sequencer
  import compare_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       DigitSupply,
  input  logic             Start,
  input  logic             EarlyExit,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic             Equal,
  output logic [IDX_W-1:0] MismatchIndex
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic             exit_q;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] idx_acc;
  logic             eq_acc;
  logic             seen;
  logic             xnor_y;
  logic             busy_q, done_q, equal_q;
  logic [IDX_W-1:0] mis_idx_q;

  logic miss_now, first_miss, last_bit;

  xnor_B_to_A u_xnor (
    .DigitSupply (DigitSupply),
    .A           (sh_a[0]),
    .B           (sh_b[0]),
    .Y           (xnor_y)
  );

  assign miss_now   = ~xnor_y;
  assign first_miss = miss_now & ~seen;
  assign last_bit   = (bit_idx == LAST_IDX);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = SHIFT;
      // With early exit, any mismatch here is necessarily the first one.
      SHIFT:   if (last_bit || (miss_now && exit_q)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sh_a      <= '0;
      sh_b      <= '0;
      exit_q    <= 1'b0;
      bit_idx   <= '0;
      idx_acc   <= '0;
      eq_acc    <= 1'b0;
      seen      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      equal_q   <= 1'b0;
      mis_idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            sh_a    <= OperandA;
            sh_b    <= OperandB;
            exit_q  <= EarlyExit;
            bit_idx <= '0;
            idx_acc <= '0;
            eq_acc  <= 1'b1;
            seen    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (first_miss) begin
            idx_acc <= bit_idx;
            eq_acc  <= 1'b0;
            seen    <= 1'b1;
          end
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          bit_idx <= bit_idx + IDX_W'(1);
          // Publish the verdict including the bit consumed on this edge,
          // so the result is valid in the same cycle Done rises.
          if (state_nxt == DONE) begin
            done_q    <= 1'b1;
            equal_q   <= eq_acc & xnor_y;
            mis_idx_q <= first_miss ? bit_idx : idx_acc;
          end
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign Busy          = busy_q;
  assign Done          = done_q;
  assign Equal         = equal_q;
  assign MismatchIndex = mis_idx_q;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Bench for serial_compare_sequencer (WIDTH=8): directed scenarios plus
// random jobs checked against a first-mismatch / latency reference model.
module tb_serial_compare_sequencer;

  localparam int WIDTH = 8;
  localparam int IDX_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       supply = 2'b10;
  logic             start, early_exit;
  logic [WIDTH-1:0] op_a, op_b;
  logic             busy, done, equal;
  logic [IDX_W-1:0] mis_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_compare_sequencer #(.WIDTH(WIDTH)) dut (
    .Clock         (clk),
    .Reset         (rst),
    .DigitSupply   (supply),
    .Start         (start),
    .EarlyExit     (early_exit),
    .OperandA      (op_a),
    .OperandB      (op_b),
    .Busy          (busy),
    .Done          (done),
    .Equal         (equal),
    .MismatchIndex (mis_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lowest differing bit decides the verdict; the job lasts
  // WIDTH edges unless early exit stops it right after that bit.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input bit ex, output int lat, output bit eq, output int idx);
    logic [WIDTH-1:0] d;
    d   = a ^ b;
    idx = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) idx = i;
    eq  = (d == '0);
    lat = (ex && !eq) ? idx + 1 : WIDTH;
  endfunction

  // Called just after an edge with the DUT idle.
  task automatic run_job(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit ex);
    int lat, idx, n;
    bit eq;
    model(a, b, ex, lat, eq, idx);
    start = 1'b1; op_a = a; op_b = b; early_exit = ex;
    tick();
    start = 1'b0; op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); early_exit = 1'($urandom);
    chk({tag, ".busy_on"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".equal"}, equal, eq);
    chk({tag, ".idx"}, mis_idx, idx);
    tick();
    chk({tag, ".done_off"}, done, 0);
    chk({tag, ".busy_off"}, busy, 0);
    chk({tag, ".equal_hold"}, equal, eq);
    chk({tag, ".idx_hold"}, mis_idx, idx);
  endtask

  initial begin
    int cnt, first;
    int dt[$];
    logic [WIDTH-1:0] a, b;

    rst = 1'b1; start = 1'b0; early_exit = 1'b0; op_a = '0; op_b = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.equal", equal, 0);
      chk("rst.idx", mis_idx, 0);
      tick();
    end

    run_job("eq_a5", 8'hA5, 8'hA5, 1'b0);
    run_job("ee_bit2", 8'hA5, 8'hA1, 1'b1);
    run_job("two_miss", 8'h00, 8'h82, 1'b0);
    run_job("ee_last", 8'h00, 8'h80, 1'b1);
    run_job("ee_bit0", 8'h01, 8'h00, 1'b1);

    // Second Start during a job must be ignored.
    start = 1'b1; op_a = 8'h3C; op_b = 8'h3C; early_exit = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; op_a = 8'hFF; op_b = 8'h00; early_exit = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0; first = -1;
    for (int e = 5; e <= 20; e++) begin
      tick();
      if (done) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    chk("ign.done_count", cnt, 1);
    chk("ign.done_edge", first, 8);
    chk("ign.equal", equal, 1);

    // Reset mid-SHIFT discards the job.
    start = 1'b1; op_a = 8'h00; op_b = 8'hFF; early_exit = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.equal", equal, 0);
    chk("midrst.idx", mis_idx, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    chk("midrst.quiet", cnt, 0);

    // Start held high: back-to-back jobs.
    start = 1'b1; op_a = 8'h5A; op_b = 8'h5A; early_exit = 1'b0;
    for (int i = 0; i < 40 && dt.size() < 3; i++) begin
      tick();
      if (done) dt.push_back(cyc);
    end
    start = 1'b0;
    chk("b2b.count", dt.size(), 3);
    if (dt.size() == 3) begin
      chk("b2b.gap1", dt[1] - dt[0], 10);
      chk("b2b.gap2", dt[2] - dt[1], 10);
    end
    cnt = 0;
    while (busy && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("b2b.drain", busy, 0);
    chk("b2b.equal", equal, 1);

    // Random jobs, biased toward equal and single-bit-difference operands.
    for (int j = 0; j < 40; j++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(2))
        0:       b = a;
        1:       b = a ^ (WIDTH'(1) << $urandom_range(WIDTH - 1));
        default: b = WIDTH'($urandom);
      endcase
      run_job($sformatf("rnd%0d", j), a, b, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
